// File: rtl/muldiv_pkg.sv
// ============================================================================
//  Module   : muldiv_pkg
//  Purpose  : Shared definitions for the iterative multiply/divide unit:
//             data width, funct3 opcode encoding, FSM state encoding and
//             the divide-by-zero quotient constant.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package muldiv_pkg;

    localparam int XLEN = 32;

    // Quotient returned for any divide by zero (all ones).
    localparam logic [XLEN-1:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

    // Most negative signed value; the only dividend that can overflow.
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : muldiv_pkg

`default_nettype wire

// File: rtl/muldiv_if.sv
// ============================================================================
//  Module   : muldiv_if
//  Purpose  : Request/response bundle of the multiply/divide unit.
//  Signals  : start, funct3, srcA, srcB, flush   (requester -> unit)
//             busy, resultValid, result          (unit -> requester)
//  Modports : master = requester side, slave = muldiv unit side
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface muldiv_if;
    import muldiv_pkg::*;

    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] srcA;
    logic [XLEN-1:0] srcB;
    logic            flush;
    logic            busy;
    logic            resultValid;
    logic [XLEN-1:0] result;

    modport master (
        output start, funct3, srcA, srcB, flush,
        input  busy, resultValid, result
    );

    modport slave (
        input  start, funct3, srcA, srcB, flush,
        output busy, resultValid, result
    );

endinterface : muldiv_if

`default_nettype wire

// File: rtl/muldiv.sv
// ============================================================================
//  Module   : muldiv
//  Purpose  : Iterative radix-2 multiply/divide unit (RV32M operations).
//             Multiply is shift-add, divide is restoring shift-subtract;
//             both run on magnitudes in one shared 64-bit shift register
//             for 32 steps, followed by sign correction.
//  Ports    : clk   - clock, rising edge
//             rstN  - asynchronous active-low reset
//             bus   - muldiv_if.slave (start/funct3/srcA/srcB/flush in,
//                     busy/resultValid/result out)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv
    import muldiv_pkg::*;
(
    input  wire      clk,
    input  wire      rstN,
    muldiv_if.slave  bus
);

    state_e            state_q,  state_d;
    op_e               op_q,     op_d;
    logic [4:0]        cnt_q,    cnt_d;
    logic [2*XLEN-1:0] acc_q,    acc_d;     // {hi, lo} shared shift register
    logic [XLEN-1:0]   opb_q,    opb_d;     // |multiplicand| or |divisor|
    logic              neg_q,    neg_d;     // negate the final value
    logic              busy_q,   busy_d;
    logic              valid_q,  valid_d;
    logic [XLEN-1:0]   result_q, result_d;

    // ---------------------------------------------------------------------
    // Request decode (only consumed in IDLE)
    // ---------------------------------------------------------------------
    op_e             w_req_op;
    logic            w_a_signed, w_b_signed;
    logic            w_a_neg, w_b_neg;
    logic [XLEN-1:0] w_abs_a, w_abs_b;
    logic            w_div_zero, w_overflow;

    always_comb begin
        w_req_op   = op_e'(bus.funct3);
        w_a_signed = (w_req_op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
        w_b_signed = (w_req_op inside {OP_MULH, OP_DIV, OP_REM});
        w_a_neg    = w_a_signed & bus.srcA[XLEN-1];
        w_b_neg    = w_b_signed & bus.srcB[XLEN-1];
        w_abs_a    = w_a_neg ? -bus.srcA : bus.srcA;
        w_abs_b    = w_b_neg ? -bus.srcB : bus.srcB;
        w_div_zero = bus.funct3[2] && (bus.srcB == '0);
        w_overflow = (w_req_op inside {OP_DIV, OP_REM}) &&
                     (bus.srcA == INT_MIN) && (bus.srcB == '1);
    end

    // ---------------------------------------------------------------------
    // One radix-2 step on the shared register, plus final sign correction
    // ---------------------------------------------------------------------
    logic [XLEN:0]     w_mul_sum;
    logic [XLEN:0]     w_div_diff;
    logic [2*XLEN-1:0] w_step;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_final;

    always_comb begin
        // Multiply: lo holds the remaining multiplier bits, hi accumulates.
        w_mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                     (acc_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
        // Divide: trial-subtract from the 33-bit remainder seen after the
        // left shift; bit XLEN of the difference is the borrow.
        w_div_diff = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opb_q};

        if (op_q[2]) begin
            w_step = w_div_diff[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                      : {w_div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            w_step = {w_mul_sum, acc_q[XLEN-1:1]};
        end

        w_prod = neg_q ? -w_step : w_step;

        case (op_q)
            OP_MUL:                       w_final = w_prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_final = w_prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              w_final = neg_q ? -w_step[XLEN-1:0]
                                                          :  w_step[XLEN-1:0];
            default:                      w_final = neg_q ? -w_step[2*XLEN-1:XLEN]
                                                          :  w_step[2*XLEN-1:XLEN];
        endcase
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        neg_d    = neg_q;
        busy_d   = busy_q;
        valid_d  = 1'b0;
        result_d = result_q;

        if (bus.flush) begin
            state_d = IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        op_d   = w_req_op;
                        cnt_d  = '0;
                        acc_d  = {{XLEN{1'b0}}, w_abs_a};
                        opb_d  = w_abs_b;
                        // Remainder follows the dividend; everything else
                        // is negative when exactly one operand is.
                        neg_d  = (w_req_op inside {OP_REM, OP_REMU}) ? w_a_neg
                                                                     : (w_a_neg ^ w_b_neg);
                        busy_d = 1'b1;
                        if (w_div_zero) begin
                            state_d  = DONE;
                            valid_d  = 1'b1;
                            result_d = (w_req_op inside {OP_DIV, OP_DIVU}) ? DIV_ZERO_QUOT
                                                                           : bus.srcA;
                        end else if (w_overflow) begin
                            state_d  = DONE;
                            valid_d  = 1'b1;
                            result_d = (w_req_op == OP_DIV) ? INT_MIN : '0;
                        end else begin
                            state_d  = CALC;
                        end
                    end
                end
                CALC: begin
                    acc_d = w_step;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d  = DONE;
                        valid_d  = 1'b1;
                        result_d = w_final;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q  <= IDLE;
            op_q     <= OP_MUL;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            neg_q    <= neg_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            result_q <= result_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.resultValid = valid_q;
    assign bus.result      = result_q;

endmodule : muldiv

`default_nettype wire

// File: doc/muldiv.md
MULDIV -- requirements
Module: muldiv

Interface
REQ-001: The module SHALL have one clock and an asynchronous, active-low reset. Ports are listed below as name, direction, width, meaning.
REQ-002: clk  input  1  the single clock; all state updates on its rising edge.
REQ-003: rstN  input  1  asynchronous active-low reset.
REQ-004: start  input  1  request; sampled only while IDLE.
REQ-005: funct3  input  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006: srcA  input  32  multiplicand or dividend.
REQ-007: srcB  input  32  multiplier or divisor.
REQ-008: flush  input  1  abort any operation in progress.
REQ-009: busy  output  1  high whenever the unit is not IDLE.
REQ-010: resultValid  output  1  one-cycle pulse marking result as new.
REQ-011: result  output  32  final value; holds until the next accepted start.

Function
REQ-012: The states SHALL be IDLE, CALC and DONE.
REQ-013: In IDLE, start=1 at a rising edge SHALL accept the request: it latches funct3, latches the absolute values of the operands per signedness, latches the result sign, clears the 5-bit counter and enters CALC.
REQ-014: Signedness SHALL be: MULH, DIV and REM treat both operands as signed; MULHSU treats srcA as signed and srcB as unsigned; MUL, MULHU, DIVU and REMU treat both as unsigned magnitudes.
REQ-015: In CALC, each cycle SHALL perform one radix-2 step: shift-add for multiply (64-bit product) or restoring shift-subtract for divide (32-bit quotient and remainder).
REQ-016: When counter==31 in CALC, the unit SHALL apply sign correction, register result and enter DONE. The quotient is negated if the operand signs differ; the remainder takes the dividend's sign; the product is negated if its sign is negative.
REQ-017: MUL SHALL return product[31:0]. MULH, MULHSU and MULHU SHALL return product[63:32]. DIV/DIVU SHALL return the quotient. REM/REMU SHALL return the remainder.
REQ-018: DONE SHALL assert resultValid for exactly one cycle and return to IDLE on the next edge.
REQ-019: Iterative latency: resultValid SHALL be high in the 34th cycle counting the accepting cycle as cycle 1. This is 33 edges after acceptance.
REQ-020: Divide by zero SHALL bypass CALC and go directly to DONE, with resultValid in cycle 2. DIV/DIVU return 0xFFFFFFFF; REM/REMU return srcA.
REQ-021: Signed overflow (DIV or REM with srcA=0x80000000 and srcB=0xFFFFFFFF) SHALL bypass CALC and go directly to DONE. DIV returns 0x80000000; REM returns 0.
REQ-022: start while busy=1 SHALL be ignored, with no queueing.
REQ-023: flush=1 SHALL force IDLE on the next edge from any state, with no resultValid and result unchanged. flush takes priority over start in the same cycle.
REQ-024: Operand inputs SHALL be ignored after acceptance. Changing srcA, srcB or funct3 during CALC has no effect.

Reset
REQ-025: rstN=0 SHALL immediately force IDLE, busy=0, resultValid=0, result=0, counter=0 and clear the internal operand registers.
REQ-026: Reset during CALC or DONE SHALL discard the operation, with no resultValid after release.
REQ-027: The first start SHALL be accepted at the first rising edge with rstN=1.

Structure
REQ-028: The shared package muldiv_pkg SHALL hold: XLEN=32; a funct3 opcode enum; a state enum (IDLE, CALC, DONE); the divide-by-zero quotient constant 0xFFFFFFFF.
REQ-029: The block SHALL be a single module with no sub-module. The multiply and divide datapaths share the shift register and the counter.

Verification
REQ-030: MUL with srcA=7, srcB=0xFFFFFFFD SHALL give result=0xFFFFFFEB, with resultValid in cycle 34 and busy high in cycles 2-34.
REQ-031: Upper-product cases SHALL give:
- MULH 0x80000000 × 0x80000000 -> 0x40000000.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE.
- MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-032: Signed divide cases SHALL give:
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD.
- REM 0xFFFFFFF9 / 2 -> 0xFFFFFFFF.
- DIVU 0xFFFFFFF9 / 2 -> 0x7FFFFFFC.
REQ-033: Special cases SHALL give, each with resultValid in cycle 2:
- DIVU 5 / 0 -> 0xFFFFFFFF.
- REMU 5 / 0 -> 5.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
- REM of the same operands -> 0.
REQ-034: Control cases SHALL behave as follows:
- A start pulse at cycle 10 of a running MUL is ignored, and the original result is returned.
- flush at cycle 10 of a DIV gives busy=0 next cycle, no resultValid, and result unchanged.
- rstN low mid-CALC clears busy asynchronously, and no resultValid follows.
